// File: rtl/imem_boot_ctrl_if.sv
// Bus bundle for the instruction-memory boot controller.
// Groups the boot-load stream, the CPU fetch port and the memory port.
//   slave  : controller side (imem_boot_ctrl)
//   master : environment side (loader, CPU, memory)
// Signals:
//   ld_valid/ld_ready/ld_data/ld_last : boot-load word stream
//   reload                            : restart boot-load pulse
//   cpu_req/cpu_pc                    : fetch request, byte address
//   cpu_instr/cpu_valid/cpu_fault     : fetch response, one cycle later
//   cpu_hold                          : CPU stall / keep-in-reset
//   mem_we/mem_addr/mem_wdata/mem_rdata : single-port memory
//   boot_done/words_loaded            : status
interface imem_boot_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              reload;
    logic              cpu_req;
    logic [31:0]       cpu_pc;
    logic [DATA_W-1:0] cpu_instr;
    logic              cpu_valid;
    logic              cpu_fault;
    logic              cpu_hold;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              boot_done;
    logic [ADDR_W:0]   words_loaded;

    modport slave (
        input  ld_valid, ld_data, ld_last, reload, cpu_req, cpu_pc, mem_rdata,
        output ld_ready, cpu_instr, cpu_valid, cpu_fault, cpu_hold,
               mem_we, mem_addr, mem_wdata, boot_done, words_loaded
    );

    modport master (
        output ld_valid, ld_data, ld_last, reload, cpu_req, cpu_pc, mem_rdata,
        input  ld_ready, cpu_instr, cpu_valid, cpu_fault, cpu_hold,
               mem_we, mem_addr, mem_wdata, boot_done, words_loaded
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot controller.
// Owns a single-port 2**ADDR_W x DATA_W instruction memory. After reset it
// streams a boot image into the memory from word 0 while holding the CPU,
// then serves CPU fetches with one-cycle latency. A reload pulse returns it
// to boot-load at any time.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : imem_boot_ctrl_if.slave (load stream, fetch port, memory port, status)
//
// state | meaning
// LOAD  | accepting boot words, writing memory at wr_ptr, CPU held
// RUN   | image loaded, serving CPU fetches from memory
module imem_boot_ctrl #(
    parameter int                ADDR_W    = 10,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
    input logic             clk,
    input logic             rst,
    imem_boot_ctrl_if.slave bus
);
    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   words_loaded_q;
    logic              valid_q;
    logic              fault_q;
    logic              hold_q;
    logic              done_q;

    logic ld_ready_c;
    logic handshake;
    logic pc_fault;

    // A reload in LOAD takes priority over any word offered that cycle.
    assign ld_ready_c = (state == LOAD) && !bus.reload;
    assign handshake  = ld_ready_c && bus.ld_valid;

    // Misaligned, or addressing beyond the memory.
    assign pc_fault = (bus.cpu_pc[1:0] != 2'b00) || (bus.cpu_pc[31:ADDR_W+2] != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= LOAD;
            wr_ptr         <= '0;
            words_loaded_q <= '0;
            valid_q        <= 1'b0;
            fault_q        <= 1'b0;
            hold_q         <= 1'b1;
            done_q         <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    valid_q <= 1'b0;
                    fault_q <= 1'b0;
                    if (bus.reload) begin
                        wr_ptr         <= '0;
                        words_loaded_q <= '0;
                    end else if (handshake) begin
                        wr_ptr         <= wr_ptr + ADDR_W'(1);
                        words_loaded_q <= words_loaded_q + (ADDR_W+1)'(1);
                        // Last word of the image, or the memory is now full.
                        if (bus.ld_last || (wr_ptr == PTR_MAX)) begin
                            state  <= RUN;
                            hold_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.reload) begin
                        // Reload wins over a same-cycle fetch: no response follows.
                        state          <= LOAD;
                        wr_ptr         <= '0;
                        words_loaded_q <= '0;
                        valid_q        <= 1'b0;
                        fault_q        <= 1'b0;
                        hold_q         <= 1'b1;
                        done_q         <= 1'b0;
                    end else begin
                        valid_q <= bus.cpu_req;
                        fault_q <= bus.cpu_req && pc_fault;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    assign bus.ld_ready     = ld_ready_c;
    assign bus.mem_we       = handshake;
    assign bus.mem_addr     = (state == RUN) ? bus.cpu_pc[ADDR_W+1:2] : wr_ptr;
    assign bus.mem_wdata    = bus.ld_data;
    assign bus.cpu_valid    = valid_q;
    assign bus.cpu_fault    = fault_q;
    assign bus.cpu_instr    = fault_q ? NOP_INSTR : bus.mem_rdata;
    assign bus.cpu_hold     = hold_q;
    assign bus.boot_done    = done_q;
    assign bus.words_loaded = words_loaded_q;
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: directed table of fetches, directed
// load/reload/reset sequences, and a randomized full-memory load plus random
// fetches checked against a simple image model.
module tb_imem_boot_ctrl;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk;
    logic rst;

    imem_boot_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_boot_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_INSTR(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory the controller owns: registered read, one cycle latency.
    logic [DATA_W-1:0] mem [DEPTH];
    int wr_count = 0;
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wr_count <= wr_count + 1;
        end
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Reference: what the bench has sent, indexed by word, and its write pointer.
    logic [31:0] img [DEPTH];
    int exp_ptr;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] data, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = data;
        bus.ld_last  = last;
        #1;
        chk("ld_ready_on_word", bus.ld_ready, 1);
        chk("mem_we_on_word", bus.mem_we, 1);
        chk("mem_addr_on_word", bus.mem_addr, exp_ptr);
        chk("mem_wdata_on_word", bus.mem_wdata, data);
        img[exp_ptr] = data;
        exp_ptr++;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic pulse_reload();
        bus.reload = 1'b1;
        tick();
        bus.reload = 1'b0;
        exp_ptr = 0;
    endtask

    function automatic logic spec_fault(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc >= 32'(DEPTH * 4));
    endfunction

    task automatic fetch1(input string name, input logic [31:0] pc);
        logic f;
        f = spec_fault(pc);
        bus.cpu_req = 1'b1;
        bus.cpu_pc  = pc;
        tick();
        bus.cpu_req = 1'b0;
        #1;
        chk({name, "_valid"}, bus.cpu_valid, 1);
        chk({name, "_fault"}, bus.cpu_fault, f);
        chk({name, "_instr"}, bus.cpu_instr, f ? NOP : img[pc >> 2]);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [9:0]  addr;
        logic        fault;
        logic [31:0] instr;
    } fetch_vec_t;

    fetch_vec_t fv [7];

    initial begin
        int bad;
        int k;
        int cyc;
        int wc0;
        logic        v;
        logic [31:0] d;
        logic        prev_req;
        logic        prev_fault;
        logic [31:0] prev_instr;
        logic        req;
        logic [31:0] pc;

        fv[0] = '{32'h0000_0008, 10'd2, 1'b0, 32'h0000_00A2};
        fv[1] = '{32'h0000_0000, 10'd0, 1'b0, 32'h0000_00A0};
        fv[2] = '{32'h0000_0004, 10'd1, 1'b0, 32'h0000_00A1};
        fv[3] = '{32'h0000_0006, 10'd1, 1'b1, NOP};
        fv[4] = '{32'h0000_1000, 10'd0, 1'b1, NOP};
        fv[5] = '{32'h0000_000C, 10'd3, 1'b0, 32'h0000_00A3};
        fv[6] = '{32'h8000_0004, 10'd1, 1'b1, NOP};

        bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0; bus.reload = 0;
        bus.cpu_req = 0; bus.cpu_pc = '0;
        rst = 1'b1;
        exp_ptr = 0;
        tick(); tick();
        rst = 1'b0;
        #1;

        // Reset values
        chk("rst_ld_ready", bus.ld_ready, 1);
        chk("rst_cpu_hold", bus.cpu_hold, 1);
        chk("rst_boot_done", bus.boot_done, 0);
        chk("rst_cpu_valid", bus.cpu_valid, 0);
        chk("rst_cpu_fault", bus.cpu_fault, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_words_loaded", bus.words_loaded, 0);

        // Boot image A0..A3 with an idle gap; cpu_req is ignored in LOAD
        send_word(32'hA0, 1'b0);
        send_word(32'hA1, 1'b0);
        bus.cpu_req = 1'b1; bus.cpu_pc = 32'h4;
        #1;
        chk("gap_mem_we", bus.mem_we, 0);
        chk("gap_mem_addr", bus.mem_addr, 2);
        tick();
        bus.cpu_req = 1'b0;
        chk("load_cpu_valid", bus.cpu_valid, 0);
        send_word(32'hA2, 1'b0);
        chk("hold_before_last", bus.cpu_hold, 1);
        send_word(32'hA3, 1'b1);
        chk("run_cpu_hold", bus.cpu_hold, 0);
        chk("run_boot_done", bus.boot_done, 1);
        chk("run_words_loaded", bus.words_loaded, 4);
        chk("run_ld_ready", bus.ld_ready, 0);

        // Table-driven fetches, issued back-to-back
        for (int i = 0; i <= 7; i++) begin
            if (i < 7) begin
                bus.cpu_req = 1'b1;
                bus.cpu_pc  = fv[i].pc;
            end else begin
                bus.cpu_req = 1'b0;
            end
            #1;
            if (i < 7) chk("tbl_mem_addr", bus.mem_addr, fv[i].addr);
            if (i > 0) begin
                chk("tbl_valid", bus.cpu_valid, 1);
                chk("tbl_fault", bus.cpu_fault, fv[i-1].fault);
                chk("tbl_instr", bus.cpu_instr, fv[i-1].instr);
            end
            tick();
        end
        chk("tbl_idle_valid", bus.cpu_valid, 0);

        // Reload together with a fetch: reload wins
        bus.cpu_req = 1'b1; bus.cpu_pc = 32'h0;
        pulse_reload();
        bus.cpu_req = 1'b0;
        chk("rl_cpu_valid", bus.cpu_valid, 0);
        chk("rl_cpu_hold", bus.cpu_hold, 1);
        chk("rl_boot_done", bus.boot_done, 0);
        chk("rl_words_loaded", bus.words_loaded, 0);
        send_word(32'hB0, 1'b0);
        send_word(32'hB1, 1'b1);
        chk("rl2_words_loaded", bus.words_loaded, 2);
        fetch1("rl_f0", 32'h0);
        fetch1("rl_f4", 32'h4);
        fetch1("rl_f8", 32'h8);

        // Reload while in LOAD blocks that cycle's word
        pulse_reload();
        send_word(32'hD0, 1'b0);
        chk("ld_one_word", bus.words_loaded, 1);
        bus.reload = 1'b1; bus.ld_valid = 1'b1; bus.ld_data = 32'hDEAD; bus.ld_last = 1'b1;
        #1;
        chk("rl_in_load_ready", bus.ld_ready, 0);
        chk("rl_in_load_we", bus.mem_we, 0);
        tick();
        bus.reload = 1'b0; bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        exp_ptr = 0;
        chk("rl_in_load_words", bus.words_loaded, 0);
        chk("rl_in_load_done", bus.boot_done, 0);
        // ld_last on the very first word
        send_word(32'hE0, 1'b1);
        chk("first_last_words", bus.words_loaded, 1);
        chk("first_last_done", bus.boot_done, 1);
        fetch1("first_last_f0", 32'h0);
        fetch1("first_last_f4", 32'h4);

        // Full memory, random valid gaps, ld_last only offered without valid
        pulse_reload();
        wc0 = wr_count;
        k = 0; cyc = 0; bad = 0;
        while (k < DEPTH && cyc < 8000) begin
            v = 1'($urandom_range(0, 1));
            d = $urandom;
            bus.ld_valid = v;
            bus.ld_data  = d;
            bus.ld_last  = v ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            if (bus.ld_ready !== 1'b1 || bus.mem_we !== v || bus.mem_addr !== 10'(k)) bad++;
            if (v) begin
                img[k] = d;
                k++;
            end
            tick();
            cyc++;
        end
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        chk("full_budget", k, DEPTH);
        chk("full_cycle_errs", bad, 0);
        chk("full_words_loaded", bus.words_loaded, DEPTH);
        chk("full_boot_done", bus.boot_done, 1);
        chk("full_write_count", wr_count - wc0, DEPTH);
        bus.ld_valid = 1'b1; bus.ld_data = 32'h1234_5678;
        #1;
        chk("full_extra_ready", bus.ld_ready, 0);
        chk("full_extra_we", bus.mem_we, 0);
        tick();
        bus.ld_valid = 1'b0;
        chk("full_extra_words", bus.words_loaded, DEPTH);

        // Random fetches against the image model
        bad = 0; k = 0;
        prev_req = 1'b0; prev_fault = 1'b0; prev_instr = '0;
        for (int c = 0; c <= 400; c++) begin
            req = (c < 400) && ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0, 1:    pc = 32'($urandom_range(0, DEPTH - 1)) * 4;
                2:       pc = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
                default: pc = $urandom | (32'h1 << $urandom_range(12, 31));
            endcase
            bus.cpu_req = req;
            bus.cpu_pc  = pc;
            #1;
            if (bus.cpu_valid !== prev_req) bad++;
            else if (prev_req) begin
                k++;
                if (bus.cpu_fault !== prev_fault || bus.cpu_instr !== prev_instr) bad++;
            end
            if (req && !spec_fault(pc) && bus.mem_addr !== 10'(pc >> 2)) bad++;
            prev_req   = req;
            prev_fault = spec_fault(pc);
            prev_instr = prev_fault ? NOP : img[pc >> 2];
            tick();
        end
        bus.cpu_req = 1'b0;
        chk("rand_fetch_errs", bad, 0);
        chk("rand_fetch_seen", k > 100, 1);

        // Reset mid-load after three words
        pulse_reload();
        send_word(32'hC0, 1'b0);
        send_word(32'hC1, 1'b0);
        send_word(32'hC2, 1'b0);
        chk("mid_words", bus.words_loaded, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ptr = 0;
        chk("mid_rst_words", bus.words_loaded, 0);
        chk("mid_rst_ready", bus.ld_ready, 1);
        chk("mid_rst_hold", bus.cpu_hold, 1);
        chk("mid_rst_done", bus.boot_done, 0);
        chk("mid_rst_addr", bus.mem_addr, 0);
        send_word(32'hC8, 1'b1);
        chk("mid_rst_reload_words", bus.words_loaded, 1);

        // Reset together with a fetch: no response follows
        bus.cpu_req = 1'b1; bus.cpu_pc = 32'h0;
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.cpu_req = 1'b0;
        chk("fetch_rst_valid", bus.cpu_valid, 0);
        chk("fetch_rst_fault", bus.cpu_fault, 0);
        chk("fetch_rst_hold", bus.cpu_hold, 1);
        chk("fetch_rst_done", bus.boot_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
